core_lsu_ctrl: RTL

Sequences the single load/store unit for the TOY core. It accepts one memory request per instruction from the decoder cascade's preempt interface (load, store, load indirect, store indirect) and drives a ready/grant memory port. It also drives the stdin/stdout handshake for TOY address 0xFF, writes loaded data back to the register file, and reports completion so the front end can release its stall and clear the destination's dirty bit.

---
 rtl/core_lsu_ctrl_pkg.sv | 26 ++
 rtl/core_lsu_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/core_lsu_ctrl_pkg.sv
// Shared types and constants for the TOY load/store unit controller.
package core_lsu_ctrl_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned RD_W   = 4;

   localparam logic [ADDR_W-1:0] IO_ADDR = 8'hFF;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MEM_REQ  = 3'd1,
      MEM_WAIT = 3'd2,
      IO_IN    = 3'd3,
      IO_OUT   = 3'd4,
      WB       = 3'd5
   } lsu_state_e;

   typedef struct packed {
      logic              wen;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [RD_W-1:0]   rd;
   } lsu_req_t;

endpackage

// File: rtl/core_lsu_ctrl.sv
// Load/store sequencer for the TOY core: memory port, stdin/stdout at IO_ADDR, register writeback.
// Build option TOY_LSU_MMIO_EN routes IO_ADDR to the stdin/stdout handshake; otherwise it is plain memory.
module core_lsu_ctrl
   import core_lsu_ctrl_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              lsu_en_i,
   input  logic              lsu_wen_i,
   input  logic              lsu_kind_i,
   input  logic [ADDR_W-1:0] addr_imm_i,
   input  logic [DATA_W-1:0] addr_reg_i,
   input  logic [DATA_W-1:0] store_data_i,
   input  logic [RD_W-1:0]   rd_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              arf_wen_o,
   output logic [RD_W-1:0]   arf_waddr_o,
   output logic [DATA_W-1:0] arf_wdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              stdin_valid_i,
   input  logic [DATA_W-1:0] stdin_data_i,
   output logic              stdin_ready_o,
   output logic              stdout_valid_o,
   output logic [DATA_W-1:0] stdout_data_o,
   input  logic              stdout_ready_i
);

   lsu_state_e state_q, state_d;
   lsu_req_t   req_q, req_d;

   logic [ADDR_W-1:0] sel_addr_c;
   logic              io_match_c;
   logic              io_hit_c;
   logic              unused_in_c;

   // State and latched request; data field doubles as the load capture register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
      end
   end

   always_comb begin
      sel_addr_c = lsu_kind_i ? addr_imm_i : addr_reg_i[ADDR_W-1:0];
      io_match_c = (sel_addr_c == IO_ADDR);
`ifdef TOY_LSU_MMIO_EN
      io_hit_c    = io_match_c;
      unused_in_c = ^addr_reg_i[DATA_W-1:ADDR_W];
`else
      io_hit_c    = 1'b0;
      unused_in_c = ^{addr_reg_i[DATA_W-1:ADDR_W], stdin_valid_i, stdin_data_i,
                      stdout_ready_i, io_match_c};
`endif
   end

   always_comb begin
      state_d        = state_q;
      req_d          = req_q;
      busy_o         = (state_q != IDLE);
      done_o         = 1'b0;
      arf_wen_o      = 1'b0;
      arf_waddr_o    = '0;
      arf_wdata_o    = '0;
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_o     = '0;
      mem_wdata_o    = '0;
      stdin_ready_o  = 1'b0;
      stdout_valid_o = 1'b0;
      stdout_data_o  = '0;

      case (state_q)
         IDLE: begin
            if (lsu_en_i) begin
               req_d.wen  = lsu_wen_i;
               req_d.addr = sel_addr_c;
               req_d.data = store_data_i;
               req_d.rd   = rd_i;
               if (io_hit_c) begin
                  state_d = lsu_wen_i ? IO_OUT : IO_IN;
               end else begin
                  state_d = MEM_REQ;
               end
            end
         end
         MEM_REQ: begin
            mem_req_o   = 1'b1;
            mem_we_o    = req_q.wen;
            mem_addr_o  = req_q.addr;
            mem_wdata_o = req_q.data;
            if (mem_gnt_i) begin
               if (req_q.wen) begin
                  done_o  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = MEM_WAIT;
               end
            end
         end
         MEM_WAIT: begin
            if (mem_rvalid_i) begin
               req_d.data = mem_rdata_i;
               state_d    = WB;
            end
         end
`ifdef TOY_LSU_MMIO_EN
         IO_IN: begin
            stdin_ready_o = 1'b1;
            if (stdin_valid_i) begin
               req_d.data = stdin_data_i;
               state_d    = WB;
            end
         end
         IO_OUT: begin
            stdout_valid_o = 1'b1;
            stdout_data_o  = req_q.data;
            if (stdout_ready_i) begin
               done_o  = 1'b1;
               state_d = IDLE;
            end
         end
`endif
         WB: begin
            arf_wen_o   = (req_q.rd != '0);
            arf_waddr_o = req_q.rd;
            arf_wdata_o = req_q.data;
            done_o      = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // An access abandoned by reset must not report completion or write the register file.
      if (rst_i) begin
         done_o    = 1'b0;
         arf_wen_o = 1'b0;
      end
   end

`ifndef SYNTHESIS
   a_no_req_while_busy: assert property (@(posedge clk_i) disable iff (rst_i)
                                         !(lsu_en_i && busy_o));
`endif

endmodule
